// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: default address width, NOP encoding, fetch FSM states.
package rv32i_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 10;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request/response channel between the PC logic (master) and the fetch responder (slave).
interface instr_fetch_responder_if #(
    parameter int unsigned ADDR_W = rv32i_pkg::ADDR_W_DEFAULT
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/instr_fetch_responder_imem_array.sv
// Instruction store: synchronous write, registered read captured only when a fetch is accepted.
module imem_array
    import rv32i_pkg::*;
#(
    parameter int unsigned WORD_AW = ADDR_W_DEFAULT - 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [WORD_AW-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic               re,
    input  logic [WORD_AW-1:0] raddr,
    output logic [31:0]        rdata
);
    localparam int unsigned DEPTH = 2 ** WORD_AW;

    logic [31:0] mem [DEPTH];

    // Store contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read returns the pre-write word on a same-cycle write/accept collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: accepts a PC fetch, returns the stored word after LATENCY cycles.
// Optional misaligned-fetch detection is enabled by defining IFETCH_ALIGN_CHECK_EN.
module instr_fetch_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    instr_fetch_responder_if.slave  bus,
    input  logic                    ld_we,
    input  logic [ADDR_W-3:0]       ld_addr,
    input  logic [31:0]             ld_data
);
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned WORD_AW = ADDR_W - 2;
    localparam bit          LAT_ONE = (LATENCY == 1);

    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             err_q;
    logic             accept_c;
    logic             misaligned_c;
    logic [31:0]      rd_word;

    assign accept_c = bus.req_valid && req_ready_q;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned_c = |bus.req_addr[1:0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[1:0];
    assign misaligned_c    = 1'b0;
`endif

    imem_array #(
        .WORD_AW (WORD_AW)
    ) u_imem (
        .clk   (clk),
        .reset (reset),
        .we    (ld_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (accept_c),
        .raddr (bus.req_addr[ADDR_W-1:2]),
        .rdata (rd_word)
    );

    // Fetch FSM with latency counter; handshake flags are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cnt         <= CNT_W'(LATENCY - 1);
                        err_q       <= misaligned_c;
                        req_ready_q <= 1'b0;
                        if (LAT_ONE) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state       <= RESP;
                        cnt         <= '0;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_instr = err_q ? NOP_INSTR : rd_word;

endmodule
